float_mult_arbiter: RTL and testbench
=====================================

# float_mult_arbiter

Round-robin arbiter that shares one `f_mult` floating-point multiplier between two independent requesters, such as two discriminant or polynomial sequencers. It issues one multiplication at a time, records which requester owns the in-flight operation, and routes the registered result and error flag back to that owner only. It sits between the requester FSMs and the single `f_mult` instance, so several arithmetic controllers can share one multiplier.

## Interface
Parameters:
- FLEN, from `config-shared.vh` (normally 64), operand/result width in bits.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  reset: synchronous, active-high.
- req0_vld  in  1  requester 0 has an operation pending. Must hold with its operands stable until req0_rdy.
- req0_a, req0_b  in  FLEN  requester 0 operands.
- req0_rdy  out  1  one-cycle accept pulse; the operation is issued this cycle.
- rsp0_vld  out  1  one-cycle result pulse for requester 0.
- rsp0_res  out  FLEN  result; holds its value until the next rsp0_vld.
- rsp0_err  out  1  `f_mult` error for this operation; valid with rsp0_vld.
- req1_vld, req1_a, req1_b, req1_rdy, rsp1_vld, rsp1_res, rsp1_err  same as above, for requester 1.
- mult_a, mult_b  out  FLEN  to `f_mult` a/b.
- mult_up_valid  out  1  to `f_mult` up_valid.
- mult_res  in  FLEN  from `f_mult` res.
- mult_down_valid  in  1  from `f_mult` down_valid.
- mult_busy  in  1  from `f_mult` busy.
- mult_error  in  1  from `f_mult` error.
- busy  out  1  an operation is in flight (state WAIT).

## Operation
- States: IDLE, WAIT. Registers: state, owner (1 bit), prio (1 bit, the requester favoured next).
- **IDLE**
  - If (req0_vld | req1_vld) & !mult_busy, grant one requester:
    - If only one requester is valid, grant it.
    - If both are valid, grant the one selected by prio.
  - In the grant cycle:
    - mult_a/mult_b are driven combinationally from the granted requester's operands.
    - mult_up_valid=1 and reqN_rdy=1.
    - owner<=N, prio<=~N, state<=WAIT.
  - If no requester is valid or mult_busy=1: no issue, no rdy.
- **WAIT**
  - No grants; mult_up_valid=0.
  - On mult_down_valid:
    - rspN_res<=mult_res, rspN_err<=mult_error, rspN_vld<=1 for N=owner.
    - state<=IDLE.
- Outside the grant cycle, mult_a/mult_b are driven from requester 0's operands; they are don't-care because mult_up_valid=0.
- mult_down_valid in IDLE is spurious: ignored, no response.
- The non-owner's rsp outputs never change while the other requester's operation completes.
- The error flag is per-operation, not sticky.

## Timing
- Reset values:
  - state=IDLE, prio=0, owner=0.
  - All rdy, rsp_vld, rsp_err and mult_up_valid are 0.
  - rsp0_res=rsp1_res=0, busy=0.
- Accept is combinational from reqN_vld and mult_busy in IDLE (same-cycle rdy).
- Latency: grant at cycle T; `f_mult` down_valid at T+L; rspN_vld at T+L+1.
- Back-to-back:
  - IDLE is re-entered at T+L+1.
  - The next grant can occur at T+L+1, in the same cycle as the previous rsp_vld.
  - That requester may raise req_vld again on the cycle after its own rsp_vld.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1… starting with 0 after reset.
- reqN_vld dropping before rdy withdraws the request; this is legal and nothing is issued for it.
- rst mid-operation:
  - The in-flight result is discarded: no rsp_vld is generated.
  - `f_mult` shares rst.
  - The state is IDLE on the cycle after reset.

## Test plan
- **Single op.** After reset, req0: a=2.0 (0x4000000000000000), b=3.0 (0x4008000000000000).
  - Expect req0_rdy in the same cycle.
  - Expect rsp0_vld for 1 cycle with rsp0_res=6.0 (0x4018000000000000) and rsp0_err=0.
  - Expect rsp1_vld never asserted.
- **Simultaneous requests.** Raise req0 (1.5*2.0) and req1 (4.0*0.25) in the same cycle, held.
  - Expect req0 granted first, with rsp0_res=3.0.
  - Then req1 granted at the cycle of rsp0_vld, with rsp1_res=1.0.
  - Expect busy high exactly during both WAIT periods.
- **Fairness.** Hold both requesters valid for 6 operations.
  - Expect the grant sequence 0,1,0,1,0,1.
  - Expect exactly one rdy pulse per grant and the responses routed to the matching owner.
- **Error routing.** req1: a=+Inf (0x7FF0000000000000), b=1.0.
  - Expect rsp1_vld with rsp1_err=1.
  - A following req1 of 1.0*1.0 returns rsp1_err=0 and rsp1_res=1.0.
- **Busy gating and spurious result.**
  - Force mult_busy=1 while req0_vld=1: expect no rdy and no mult_up_valid until mult_busy=0.
  - Inject mult_down_valid in IDLE: expect no rsp pulse.
- **Reset mid-operation.** Assert rst for 1 cycle during WAIT of a req0 op.
  - Expect no rsp0_vld, busy=0 and prio=0.
  - A new req1 is then granted immediately and completes correctly.

Source files
------------

// File: rtl/float_mult_arbiter.sv
// float_mult_arbiter: round-robin sharing of one f_mult between two requesters.
// One operation in flight at a time; the result and error go back to the issuing requester only.
module float_mult_arbiter #(
    parameter int unsigned FLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_vld,
    input  logic [FLEN-1:0] req0_a,
    input  logic [FLEN-1:0] req0_b,
    output logic            req0_rdy,
    output logic            rsp0_vld,
    output logic [FLEN-1:0] rsp0_res,
    output logic            rsp0_err,
    input  logic            req1_vld,
    input  logic [FLEN-1:0] req1_a,
    input  logic [FLEN-1:0] req1_b,
    output logic            req1_rdy,
    output logic            rsp1_vld,
    output logic [FLEN-1:0] rsp1_res,
    output logic            rsp1_err,
    output logic [FLEN-1:0] mult_a,
    output logic [FLEN-1:0] mult_b,
    output logic            mult_up_valid,
    input  logic [FLEN-1:0] mult_res,
    input  logic            mult_down_valid,
    input  logic            mult_busy,
    input  logic            mult_error,
    output logic            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            prio_q, prio_d;
    logic            grant_sel;

    logic            rsp0_vld_q, rsp0_vld_d;
    logic            rsp0_err_q, rsp0_err_d;
    logic [FLEN-1:0] rsp0_res_q, rsp0_res_d;
    logic            rsp1_vld_q, rsp1_vld_d;
    logic            rsp1_err_q, rsp1_err_d;
    logic [FLEN-1:0] rsp1_res_q, rsp1_res_d;

    // State and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            rsp0_vld_q <= 1'b0;
            rsp0_err_q <= 1'b0;
            rsp0_res_q <= '0;
            rsp1_vld_q <= 1'b0;
            rsp1_err_q <= 1'b0;
            rsp1_res_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp0_err_q <= rsp0_err_d;
            rsp0_res_q <= rsp0_res_d;
            rsp1_vld_q <= rsp1_vld_d;
            rsp1_err_q <= rsp1_err_d;
            rsp1_res_q <= rsp1_res_d;
        end
    end

    // Grant selection, issue and result routing
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        prio_d        = prio_q;
        rsp0_vld_d    = 1'b0;
        rsp0_err_d    = rsp0_err_q;
        rsp0_res_d    = rsp0_res_q;
        rsp1_vld_d    = 1'b0;
        rsp1_err_d    = rsp1_err_q;
        rsp1_res_d    = rsp1_res_q;
        grant_sel     = 1'b0;
        req0_rdy      = 1'b0;
        req1_rdy      = 1'b0;
        mult_up_valid = 1'b0;
        mult_a        = req0_a;
        mult_b        = req0_b;

        case (state_q)
            IDLE: begin
                if ((req0_vld || req1_vld) && !mult_busy && !rst) begin
                    // Contention resolved by prio; a lone requester always wins
                    grant_sel     = (req0_vld && req1_vld) ? prio_q : req1_vld;
                    mult_up_valid = 1'b1;
                    req0_rdy      = ~grant_sel;
                    req1_rdy      = grant_sel;
                    mult_a        = grant_sel ? req1_a : req0_a;
                    mult_b        = grant_sel ? req1_b : req0_b;
                    owner_d       = grant_sel;
                    prio_d        = ~grant_sel;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (mult_down_valid) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rsp1_vld_d = 1'b1;
                        rsp1_res_d = mult_res;
                        rsp1_err_d = mult_error;
                    end else begin
                        rsp0_vld_d = 1'b1;
                        rsp0_res_d = mult_res;
                        rsp0_err_d = mult_error;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp0_vld = rsp0_vld_q;
    assign rsp0_err = rsp0_err_q;
    assign rsp0_res = rsp0_res_q;
    assign rsp1_vld = rsp1_vld_q;
    assign rsp1_err = rsp1_err_q;
    assign rsp1_res = rsp1_res_q;
    assign busy     = (state_q == WAIT);

endmodule

// File: tb/tb_float_mult_arbiter.sv
// tb_float_mult_arbiter: directed + randomized bench for float_mult_arbiter with a
// behavioural f_mult of configurable latency and a reference of expected grants/results.
module tb_float_mult_arbiter;

    localparam int unsigned FLEN = 64;
    localparam logic [63:0] F_0_25 = 64'h3FD0_0000_0000_0000;
    localparam logic [63:0] F_1_0  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F_1_5  = 64'h3FF8_0000_0000_0000;
    localparam logic [63:0] F_2_0  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F_3_0  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F_4_0  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] F_6_0  = 64'h4018_0000_0000_0000;
    localparam logic [63:0] F_INF  = 64'h7FF0_0000_0000_0000;

    logic            clk, rst;
    logic            req0_vld, req0_rdy, rsp0_vld, rsp0_err;
    logic [FLEN-1:0] req0_a, req0_b, rsp0_res;
    logic            req1_vld, req1_rdy, rsp1_vld, rsp1_err;
    logic [FLEN-1:0] req1_a, req1_b, rsp1_res;
    logic [FLEN-1:0] mult_a, mult_b, mult_res;
    logic            mult_up_valid, mult_down_valid, mult_busy, mult_error, busy;

    float_mult_arbiter #(.FLEN(FLEN)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_a(req0_a), .req0_b(req0_b), .req0_rdy(req0_rdy),
        .rsp0_vld(rsp0_vld), .rsp0_res(rsp0_res), .rsp0_err(rsp0_err),
        .req1_vld(req1_vld), .req1_a(req1_a), .req1_b(req1_b), .req1_rdy(req1_rdy),
        .rsp1_vld(rsp1_vld), .rsp1_res(rsp1_res), .rsp1_err(rsp1_err),
        .mult_a(mult_a), .mult_b(mult_b), .mult_up_valid(mult_up_valid),
        .mult_res(mult_res), .mult_down_valid(mult_down_valid),
        .mult_busy(mult_busy), .mult_error(mult_error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IEEE product plus an error flag for any non-finite operand or result
    function automatic logic [64:0] ref_mult(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        logic        e;
        p = $realtobits($bitstoreal(a) * $bitstoreal(b));
        e = (p[62:52] == 11'h7FF) || (a[62:52] == 11'h7FF) || (b[62:52] == 11'h7FF);
        return {e, p};
    endfunction

    function automatic logic [63:0] rand_f();
        logic [63:0] f;
        f[63]    = 1'($urandom_range(0, 1));
        f[62:52] = 11'(1003 + $urandom_range(0, 40));
        f[51:0]  = {20'($urandom), 32'($urandom)};
        return f;
    endfunction

    // Behavioural f_mult: latency lat_cfg (0 selects random 2..5), shares rst
    int          lat_cfg;
    int          m_cnt;
    logic [63:0] m_res, res_q;
    logic        m_err, err_q, dv_q;
    logic        force_busy, spur;

    assign mult_down_valid = dv_q | spur;
    assign mult_res        = res_q;
    assign mult_error      = err_q;
    assign mult_busy       = force_busy | (m_cnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            dv_q  <= 1'b0;
            res_q <= '0;
            err_q <= 1'b0;
            m_res <= '0;
            m_err <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            if (m_cnt == 0 && mult_up_valid) begin
                {m_err, m_res} <= ref_mult(mult_a, mult_b);
                m_cnt <= (lat_cfg == 0) ? int'($urandom_range(2, 5)) - 1 : lat_cfg - 1;
            end else if (m_cnt == 1) begin
                dv_q  <= 1'b1;
                res_q <= m_res;
                err_q <= m_err;
                m_cnt <= 0;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Event log: grants with the expected result they must produce, and observed responses
    int          rdy0_n = 0, rdy1_n = 0, both_n = 0, up_n = 0, busy_n = 0;
    int          grant_who[$];
    logic [64:0] exp0_q[$], exp1_q[$], rsp0_log[$], rsp1_log[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (req0_rdy) begin
                rdy0_n++;
                grant_who.push_back(0);
                exp0_q.push_back(ref_mult(req0_a, req0_b));
            end
            if (req1_rdy) begin
                rdy1_n++;
                grant_who.push_back(1);
                exp1_q.push_back(ref_mult(req1_a, req1_b));
            end
            if (req0_rdy && req1_rdy) both_n++;
            if (mult_up_valid) up_n++;
            if (busy) busy_n++;
            if (rsp0_vld) rsp0_log.push_back({rsp0_err, rsp0_res});
            if (rsp1_vld) rsp1_log.push_back({rsp1_err, rsp1_res});
        end
    end

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
    endtask

    // Ends at the negedge of the accept cycle; cycles = negedges waited
    task automatic wait_rdy(input int n, input string tag, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 64) begin
            @(negedge clk);
            cycles++;
            seen = (n == 0) ? req0_rdy : req1_rdy;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_rsp(input int n, input string tag, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 64) begin
            @(negedge clk);
            cycles++;
            seen = (n == 0) ? rsp0_vld : rsp1_vld;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last, b_g, b_r0, b_r1, b_e0, b_e1, b_rdy, b_up, b_busy;
        rst = 1'b1; req0_vld = 1'b0; req1_vld = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        force_busy = 1'b0; spur = 1'b0; lat_cfg = 3;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp0_vld", 64'(rsp0_vld), 64'd0);
        check("rst_rsp1_vld", 64'(rsp1_vld), 64'd0);
        check("rst_rsp0_res", rsp0_res, 64'd0);
        check("rst_rsp1_res", rsp1_res, 64'd0);
        check("rst_errs", 64'({rsp0_err, rsp1_err}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_up_valid", 64'(mult_up_valid), 64'd0);
        tick();
        rst = 1'b0;

        // Single op, fixed latency 3
        req0_a = F_2_0; req0_b = F_3_0; req0_vld = 1'b1;
        wait_rdy(0, "single_rdy", n);
        check("single_rdy_same_cycle", 64'(n), 64'd1);
        check("single_up_valid", 64'(mult_up_valid), 64'd1);
        check("single_mult_a", mult_a, F_2_0);
        check("single_mult_b", mult_b, F_3_0);
        tick();
        req0_vld = 1'b0;
        wait_rsp(0, "single_rsp", n);
        check("single_latency", 64'(n), 64'd4);
        check("single_res", rsp0_res, F_6_0);
        check("single_err", 64'(rsp0_err), 64'd0);
        tick();
        @(negedge clk);
        check("single_rsp_pulse", 64'(rsp0_vld), 64'd0);
        check("single_res_hold", rsp0_res, F_6_0);
        tick();
        check("single_no_rsp1", 64'(rsp1_log.size()), 64'd0);

        // Error routing on requester 1, then a clean op clears the flag
        req1_a = F_INF; req1_b = F_1_0; req1_vld = 1'b1;
        wait_rdy(1, "err_rdy", n);
        tick();
        req1_vld = 1'b0;
        wait_rsp(1, "err_rsp", n);
        check("err_flag", 64'(rsp1_err), 64'd1);
        tick();
        req1_a = F_1_0; req1_b = F_1_0; req1_vld = 1'b1;
        wait_rdy(1, "err2_rdy", n);
        tick();
        req1_vld = 1'b0;
        wait_rsp(1, "err2_rsp", n);
        check("err2_flag", 64'(rsp1_err), 64'd0);
        check("err2_res", rsp1_res, F_1_0);
        check("err_rsp0_untouched", rsp0_res, F_6_0);
        tick();
        check("err_rsp0_count", 64'(rsp0_log.size()), 64'd1);

        // Simultaneous requests, latency 4, back-to-back grant on the response cycle
        do_reset();
        lat_cfg = 4;
        b_busy = busy_n;
        req0_a = F_1_5; req0_b = F_2_0; req0_vld = 1'b1;
        req1_a = F_4_0; req1_b = F_0_25; req1_vld = 1'b1;
        wait_rdy(0, "sim_rdy0", n);
        check("sim_rdy0_first", 64'(n), 64'd1);
        check("sim_no_rdy1", 64'(req1_rdy), 64'd0);
        tick();
        req0_vld = 1'b0;
        wait_rsp(0, "sim_rsp0", n);
        check("sim_res0", rsp0_res, F_3_0);
        check("sim_rdy1_b2b", 64'(req1_rdy), 64'd1);
        check("sim_busy_gap", 64'(busy), 64'd0);
        tick();
        req1_vld = 1'b0;
        wait_rsp(1, "sim_rsp1", n);
        check("sim_res1", rsp1_res, F_1_0);
        tick();
        check("sim_busy_cycles", 64'(busy_n - b_busy), 64'd8);

        // Fairness with random operands and random latency
        do_reset();
        lat_cfg = 0;
        b_g = grant_who.size(); b_r0 = rsp0_log.size(); b_r1 = rsp1_log.size();
        b_e0 = exp0_q.size(); b_e1 = exp1_q.size(); b_rdy = rdy0_n + rdy1_n;
        req0_a = rand_f(); req0_b = rand_f(); req1_a = rand_f(); req1_b = rand_f();
        req0_vld = 1'b1; req1_vld = 1'b1;
        last = b_g;
        for (int i = 0; i < 400 && grant_who.size() < b_g + 6; i++) begin
            tick();
            if (grant_who.size() > last) begin
                if (grant_who[grant_who.size() - 1] == 0) begin
                    req0_a = rand_f(); req0_b = rand_f();
                end else begin
                    req1_a = rand_f(); req1_b = rand_f();
                end
                last = grant_who.size();
            end
        end
        req0_vld = 1'b0; req1_vld = 1'b0;
        for (int i = 0; i < 100 && rsp0_log.size() + rsp1_log.size() < b_r0 + b_r1 + 6; i++)
            tick();
        for (int i = 0; i < 6; i++)
            check($sformatf("fair_order_%0d", i),
                  64'((grant_who.size() > b_g + i) ? grant_who[b_g + i] : -1), 64'(i % 2));
        check("fair_rdy_count", 64'(rdy0_n + rdy1_n - b_rdy), 64'd6);
        check("fair_rsp0_count", 64'(rsp0_log.size() - b_r0), 64'd3);
        check("fair_rsp1_count", 64'(rsp1_log.size() - b_r1), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (rsp0_log.size() > b_r0 + k && exp0_q.size() > b_e0 + k)
                check($sformatf("fair_r0_%0d", k), rsp0_log[b_r0 + k][63:0], exp0_q[b_e0 + k][63:0]);
            else
                check($sformatf("fair_r0_missing_%0d", k), 64'd0, 64'd1);
            if (rsp1_log.size() > b_r1 + k && exp1_q.size() > b_e1 + k)
                check($sformatf("fair_r1_%0d", k), rsp1_log[b_r1 + k][63:0], exp1_q[b_e1 + k][63:0]);
            else
                check($sformatf("fair_r1_missing_%0d", k), 64'd0, 64'd1);
        end

        // Busy gating: no accept while f_mult reports busy
        lat_cfg = 3;
        force_busy = 1'b1;
        b_up = up_n; b_rdy = rdy0_n;
        req0_a = F_1_5; req0_b = F_4_0; req0_vld = 1'b1;
        repeat (5) tick();
        check("gate_no_up", 64'(up_n - b_up), 64'd0);
        check("gate_no_rdy", 64'(rdy0_n - b_rdy), 64'd0);
        force_busy = 1'b0;
        wait_rdy(0, "gate_rdy", n);
        check("gate_rdy_immediate", 64'(n), 64'd1);
        tick();
        req0_vld = 1'b0;
        wait_rsp(0, "gate_rsp", n);
        check("gate_res", rsp0_res, F_6_0);
        tick();

        // Spurious down_valid while idle
        b_r0 = rsp0_log.size(); b_r1 = rsp1_log.size();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (3) tick();
        check("spur_no_rsp", 64'(rsp0_log.size() + rsp1_log.size() - b_r0 - b_r1), 64'd0);
        check("spur_not_busy", 64'(busy), 64'd0);

        // Reset during WAIT discards the in-flight result
        lat_cfg = 5;
        b_r0 = rsp0_log.size();
        req0_a = F_2_0; req0_b = F_2_0; req0_vld = 1'b1;
        wait_rdy(0, "mid_rdy", n);
        tick();
        req0_vld = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_busy_cleared", 64'(busy), 64'd0);
        repeat (8) tick();
        check("mid_no_rsp0", 64'(rsp0_log.size() - b_r0), 64'd0);
        req1_a = F_3_0; req1_b = F_2_0; req1_vld = 1'b1;
        wait_rdy(1, "mid_rdy1", n);
        check("mid_rdy1_immediate", 64'(n), 64'd1);
        tick();
        req1_vld = 1'b0;
        wait_rsp(1, "mid_rsp1", n);
        check("mid_res1", rsp1_res, F_6_0);
        check("mid_err1", 64'(rsp1_err), 64'd0);
        tick();
        check("never_both_rdy", 64'(both_n), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
